// File: rtl/pe_array_pkg.sv
// Shared types and arithmetic helpers for the streaming PE array.
// sat_mul/sat_add are only referenced when PE_SATURATE_EN is defined.
package pe_array_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Zero-injection cycles needed for the last beat to reach PE(ROWS-1,COLS-1).
   function automatic int flush_cycles(input int rows, input int cols);
      return rows + cols - 1;
   endfunction

   function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int dw);
      logic signed [63:0] hi_s;
      logic signed [63:0] lo_s;
      hi_s = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo_s = -hi_s - 64'sd1;
      if (v > hi_s) begin
         return hi_s;
      end else if (v < lo_s) begin
         return lo_s;
      end else begin
         return v;
      end
   endfunction

   function automatic logic signed [63:0] sat_mul(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int dw);
      return sat_clamp(a * b, dw);
   endfunction

   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int dw);
      return sat_clamp(a + b, dw);
   endfunction

endpackage

// File: rtl/pe_array_stream_pe_cell.sv
// One output-stationary PE: multiply-accumulate, right/bottom pass-through and drain shift.
// PE_SATURATE_EN selects clamped product and sum instead of wrap-around.
module pe_cell
   import pe_array_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         shift,
   input  logic signed [DATA_WIDTH-1:0] a_in,
   input  logic signed [DATA_WIDTH-1:0] b_in,
   input  logic signed [DATA_WIDTH-1:0] acc_in,
   output logic signed [DATA_WIDTH-1:0] a_out,
   output logic signed [DATA_WIDTH-1:0] b_out,
   output logic signed [DATA_WIDTH-1:0] acc
);

   logic signed [DATA_WIDTH-1:0] prod_s;
   logic signed [DATA_WIDTH-1:0] sum_s;

`ifdef PE_SATURATE_EN
   // Clamped product, then clamped accumulate.
   always_comb begin
      prod_s = DATA_WIDTH'(sat_mul(64'(a_in), 64'(b_in), DATA_WIDTH));
      sum_s  = DATA_WIDTH'(sat_add(64'(acc), 64'(prod_s), DATA_WIDTH));
   end
`else
   // Self-determined width keeps only the low DATA_WIDTH product bits.
   always_comb begin
      prod_s = a_in * b_in;
      sum_s  = acc + prod_s;
   end
`endif

   // Operand pass-through and accumulator update (clear > shift > accumulate).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else begin
         a_out <= a_in;
         b_out <= b_in;
         if (clear) begin
            acc <= '0;
         end else if (shift) begin
            acc <= acc_in;
         end else begin
            acc <= sum_s;
         end
      end
   end

endmodule

// File: rtl/pe_array_stream.sv
// ROWS x COLS output-stationary systolic array with input skew, control FSM and column drain.
// PE_SATURATE_EN (see pe_cell) switches the PEs to saturating arithmetic.
module pe_array_stream
   import pe_array_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ROWS       = 16,
   parameter int COLS       = 16,
   parameter int K_WIDTH    = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [K_WIDTH-1:0]         k_len,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [COLS*DATA_WIDTH-1:0] wgt_in,
   input  logic [ROWS*DATA_WIDTH-1:0] ifm_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ROWS*DATA_WIDTH-1:0] ofm_out,
   output logic [$clog2(COLS)-1:0]    out_col,
   output logic                       busy,
   output logic                       done
);

   localparam int FLUSH_CYCLES = flush_cycles(ROWS, COLS);
   localparam int FW           = $clog2(FLUSH_CYCLES + 1);
   localparam int CW           = $clog2(COLS);

   state_t               state_r;
   logic [K_WIDTH-1:0]   k_len_r;
   logic [K_WIDTH-1:0]   beat_cnt_r;
   logic [FW-1:0]        flush_cnt_r;
   logic [CW-1:0]        out_col_r;
   logic                 in_ready_r;
   logic                 out_valid_r;
   logic                 busy_r;
   logic                 done_r;

   logic                 accept_s;
   logic                 shift_s;
   logic                 clear_s;

   logic signed [DATA_WIDTH-1:0] ifm_feed_s [ROWS];
   logic signed [DATA_WIDTH-1:0] wgt_feed_s [COLS];
   logic signed [DATA_WIDTH-1:0] ifm_edge_s [ROWS];
   logic signed [DATA_WIDTH-1:0] wgt_edge_s [COLS];
   logic signed [DATA_WIDTH-1:0] a_out_s    [ROWS][COLS];
   logic signed [DATA_WIDTH-1:0] b_out_s    [ROWS][COLS];
   logic signed [DATA_WIDTH-1:0] acc_s      [ROWS][COLS];

   assign accept_s = in_ready_r & in_valid;
   assign shift_s  = out_valid_r & out_ready;
   assign clear_s  = (state_r == IDLE) & start;

   // Bubbles and non-LOAD cycles inject zeros so they never disturb the sums.
   always_comb begin
      for (int i = 0; i < ROWS; i++) begin
         if (accept_s) begin
            ifm_feed_s[i] = ifm_in[i*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            ifm_feed_s[i] = '0;
         end
      end
      for (int j = 0; j < COLS; j++) begin
         if (accept_s) begin
            wgt_feed_s[j] = wgt_in[j*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            wgt_feed_s[j] = '0;
         end
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_ifm_skew
      if (i == 0) begin : g_direct
         assign ifm_edge_s[i] = ifm_feed_s[i];
      end else begin : g_chain
         logic signed [DATA_WIDTH-1:0] chain_r [i];
         // Row i activation delayed by i registers.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int s = 0; s < i; s++) chain_r[s] <= '0;
            end else begin
               chain_r[0] <= ifm_feed_s[i];
               for (int s = 1; s < i; s++) chain_r[s] <= chain_r[s-1];
            end
         end
         assign ifm_edge_s[i] = chain_r[i-1];
      end
   end

   for (genvar j = 0; j < COLS; j++) begin : g_wgt_skew
      if (j == 0) begin : g_direct
         assign wgt_edge_s[j] = wgt_feed_s[j];
      end else begin : g_chain
         logic signed [DATA_WIDTH-1:0] chain_r [j];
         // Column j weight delayed by j registers.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int s = 0; s < j; s++) chain_r[s] <= '0;
            end else begin
               chain_r[0] <= wgt_feed_s[j];
               for (int s = 1; s < j; s++) chain_r[s] <= chain_r[s-1];
            end
         end
         assign wgt_edge_s[j] = chain_r[j-1];
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         logic signed [DATA_WIDTH-1:0] a_in_s;
         logic signed [DATA_WIDTH-1:0] b_in_s;
         logic signed [DATA_WIDTH-1:0] acc_in_s;
         if (c == 0) begin : g_a_edge
            assign a_in_s = ifm_edge_s[r];
         end else begin : g_a_pass
            assign a_in_s = a_out_s[r][c-1];
         end
         if (r == 0) begin : g_b_edge
            assign b_in_s = wgt_edge_s[c];
         end else begin : g_b_pass
            assign b_in_s = b_out_s[r-1][c];
         end
         if (c == COLS - 1) begin : g_fill
            assign acc_in_s = '0;
         end else begin : g_shift
            assign acc_in_s = acc_s[r][c+1];
         end
         pe_cell #(.DATA_WIDTH(DATA_WIDTH)) u_pe (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (clear_s),
            .shift  (shift_s),
            .a_in   (a_in_s),
            .b_in   (b_in_s),
            .acc_in (acc_in_s),
            .a_out  (a_out_s[r][c]),
            .b_out  (b_out_s[r][c]),
            .acc    (acc_s[r][c])
         );
      end
   end

   // Column 0 accumulators are the drain output.
   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         ofm_out[r*DATA_WIDTH +: DATA_WIDTH] = acc_s[r][0];
      end
   end

   // Tile sequencing with registered handshake and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         k_len_r     <= '0;
         beat_cnt_r  <= '0;
         flush_cnt_r <= '0;
         out_col_r   <= '0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  k_len_r    <= k_len;
                  beat_cnt_r <= '0;
                  busy_r     <= 1'b1;
                  out_col_r  <= '0;
                  if (k_len != '0) begin
                     state_r    <= LOAD;
                     in_ready_r <= 1'b1;
                  end else begin
                     state_r     <= DRAIN;
                     out_valid_r <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (in_valid) begin
                  beat_cnt_r <= beat_cnt_r + K_WIDTH'(1);
                  if (beat_cnt_r + K_WIDTH'(1) == k_len_r) begin
                     state_r     <= FLUSH;
                     in_ready_r  <= 1'b0;
                     flush_cnt_r <= '0;
                  end
               end
            end
            FLUSH: begin
               if (flush_cnt_r == FW'(FLUSH_CYCLES - 1)) begin
                  state_r     <= DRAIN;
                  out_valid_r <= 1'b1;
                  out_col_r   <= '0;
               end else begin
                  flush_cnt_r <= flush_cnt_r + FW'(1);
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (out_col_r == CW'(COLS - 1)) begin
                     state_r     <= IDLE;
                     out_valid_r <= 1'b0;
                     busy_r      <= 1'b0;
                     done_r      <= 1'b1;
                     out_col_r   <= '0;
                  end else begin
                     out_col_r <= out_col_r + CW'(1);
                  end
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_col   = out_col_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: doc/pe_array_stream.md
# pe_array_stream

Parametrised successor to the fixed 16×16 PE array: a ROWS×COLS output-stationary systolic array with built-in input skewing, an internal control FSM and a ready/valid result drain. The upstream buffer streams K aligned beats of weights and IFM without pre-skewing. The block accumulates one ROWS×COLS output tile, then shifts it out one column per beat to the OFM writer. It replaces the external reset_pe/write_out_en sequencing the old array needed.

## Interface
- DATA_WIDTH, 16, signed operand/accumulator width
- ROWS, 16, PE rows (IFM lanes, output lanes)
- COLS, 16, PE columns (weight lanes, drain beats)
- K_WIDTH, 12, width of the k_len beat count
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a tile; sampled only in IDLE
- k_len  in  K_WIDTH  beats in the tile; sampled with start
- in_valid  in  1  wgt_in/ifm_in beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- wgt_in  in  COLS*DATA_WIDTH  column j weight at [j*DATA_WIDTH +: DATA_WIDTH]
- ifm_in  in  ROWS*DATA_WIDTH  row i activation at [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  ofm_out holds a result column
- out_ready  in  1  consumer accepts column
- ofm_out  out  ROWS*DATA_WIDTH  row i result at [i*DATA_WIDTH +: DATA_WIDTH]
- out_col  out  $clog2(COLS)  index of column on ofm_out
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last drain beat

## Operation
- States: IDLE → LOAD → FLUSH → DRAIN → IDLE.
- IDLE: start=1 with k_len>0 → LOAD, beat counter cleared. start with k_len=0 → DRAIN directly, which drains all-zero tile. start outside IDLE is ignored.
- LOAD: in_ready=1. Each accepted beat increments the counter. Cycles with in_valid=0 inject zero on every wgt and ifm lane (a bubble), so results are unaffected. When beat k_len is accepted → FLUSH.
- FLUSH: in_ready=0, zeros injected. Lasts exactly ROWS+COLS-1 cycles → DRAIN.
- Skew: row i IFM delayed i registers, column j weight delayed j registers, before entering the array.
- PE(i,j): acc += ifm×wgt. Product is a signed DATA_WIDTH×DATA_WIDTH multiply, low DATA_WIDTH bits kept. Accumulation wraps (two's complement) unless saturation is compiled in.
- DRAIN: out_valid=1. ofm_out = column-0 accumulators, out_col=0 first. Each out_valid&out_ready shifts every row's accumulators one column toward column 0, zero-filling column COLS-1, and increments out_col. Data is held stable while out_ready=0. After beat COLS-1 is accepted: done pulses, accumulators are already zero → IDLE.
- rst_n low at any time: state IDLE, all accumulators, skew registers and counters zero. A partial tile is discarded.

## Timing
- Reset values: in_ready=0, out_valid=0, ofm_out=0, out_col=0, busy=0, done=0.
- start at cycle T → in_ready=1 at T+1.
- Last beat accepted at cycle L → out_valid=1 at L+ROWS+COLS, independent of bubbles.
- Drain takes minimum COLS cycles; no bubble between accepted beats when out_ready stays high.
- done is high for the cycle after the final drain handshake. busy falls that same cycle. A new start is accepted in the cycle after done.
- Outputs are registered; no combinational path from in_valid or out_ready to any output except in_ready's state decode.

## Configuration
- PE_SATURATE_EN defined: the product is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] before the add, and the sum is clamped to the same range.
- PE_SATURATE_EN undefined: plain wrap-around truncation in both places.
- Timing is identical in both builds.

## Structure
- Package pe_array_pkg holds:
  - state enum (IDLE, LOAD, FLUSH, DRAIN)
  - FLUSH_CYCLES = ROWS+COLS-1 derivation helper
  - sat_add / sat_mul functions used under PE_SATURATE_EN
- One sub-module, pe_cell:
  - holds one accumulator, pass-through registers for right/bottom, and the shift-left drain mux
  - inputs: clear and shift controls from the FSM
- Skew registers and FSM live in pe_array_stream.

## Test plan
- ROWS=COLS=4, k_len=1, all wgt=2, all ifm=3, out_ready=1 → 4 drain beats, every lane 6, out_col 0..3, done one cycle after beat 3.
- ROWS=COLS=4, k_len=3, identity-like weights (col j weight=1 only on beat j), ifm row i=i+1 → column j lane i = i+1 for j<3, column 3 all zero.
- Same tile with in_valid toggling 1-0-1-0 → identical results; out_valid exactly ROWS+COLS cycles after the last accepted beat.
- out_ready held 0 for 5 cycles on beat 2 → ofm_out and out_col=2 stable throughout, no beat lost.
- Wrap build: one beat with wgt=0x7FFF and ifm=2 → lane 0xFFFE. PE_SATURATE_EN build → 0x7FFF. Both builds: wgt=0x8000, ifm=1, k_len=2 → wrap 0x0000, saturated 0x8000.
- rst_n pulsed low mid-LOAD, then a fresh k_len=1 tile of wgt=1, ifm=1 → all lanes 1, no residue from the aborted tile. k_len=0 start → 4 zero beats then done.
